// File: rtl/byte_serial_sub_pkg.sv
// Shared ALU definitions for the slice-serial subtractor: default widths,
// FSM state encoding and the packed status-flag bundle.
package byte_serial_sub_pkg;

   localparam int unsigned SLICE_DEF = 8;
   localparam int unsigned WIDTH_DEF = 32;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic borrow;
      logic zero;
      logic neg;
      logic ovf;
   } flags_t;

endpackage

// File: rtl/byte_serial_sub_cla_slice.sv
// cla_slice: SLICE-bit combinational carry-lookahead adder (s = x + y + cin).
module cla_slice
   import byte_serial_sub_pkg::*;
#(
   parameter int unsigned SLICE = SLICE_DEF
) (
   input  logic [SLICE-1:0] x,
   input  logic [SLICE-1:0] y,
   input  logic             cin,
   output logic [SLICE-1:0] s,
   output logic             cout
);

   logic [SLICE-1:0] g;
   logic [SLICE-1:0] p;
   logic [SLICE:0]   c;

   assign g = x & y;
   assign p = x ^ y;

   // Each carry expanded as g[i] | p[i]g[i-1] | ... | p[i..0]cin, no ripple.
   always_comb begin : lookahead
      logic acc;
      logic pp;
      acc  = 1'b0;
      pp   = 1'b0;
      c    = '0;
      c[0] = cin;
      for (int unsigned i = 0; i < SLICE; i++) begin
         acc = g[i];
         pp  = p[i];
         for (int unsigned k = 1; k <= i; k++) begin
            acc = acc | (pp & g[i-k]);
            pp  = pp & p[i-k];
         end
         acc    = acc | (pp & cin);
         c[i+1] = acc;
      end
   end

   assign s    = p ^ c[SLICE-1:0];
   assign cout = c[SLICE];

endmodule

// File: rtl/byte_serial_sub.sv
// byte_serial_sub: multi-cycle a - b, one SLICE-bit slice per clock, LS slice
// first, using one cla_slice and a registered carry (a + ~b + carry_in).
// Optional macro BYTE_SUB_BORROW_IN_EN adds a borrow-in port 'bin'.
module byte_serial_sub
   import byte_serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned SLICE = SLICE_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef BYTE_SUB_BORROW_IN_EN
   input  logic             bin,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zero,
   output logic             neg,
   output logic             ovf
);

   localparam int unsigned N  = WIDTH / SLICE;
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, nb_q;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             a_msb_q, b_msb_q;
   logic             carry_q;
   logic             done_q;
   logic [IW-1:0]    idx_q;
   flags_t           flags_q, flags_d;
   logic [SLICE-1:0] sum;
   logic             cout;
   logic             accept;
   logic             last;
   logic             cin0;

`ifdef BYTE_SUB_BORROW_IN_EN
   assign cin0 = ~bin;
`else
   assign cin0 = 1'b1;
`endif

   assign accept = (state_q == IDLE) && start;
   assign last   = (idx_q == IW'(N-1));

   // Operand registers shift right each RUN cycle, so the active slice is
   // always the low SLICE bits; the MSBs needed for ovf are kept separately.
   cla_slice #(.SLICE(SLICE)) u_cla (
      .x    (a_q[SLICE-1:0]),
      .y    (nb_q[SLICE-1:0]),
      .cin  (carry_q),
      .s    (sum),
      .cout (cout)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Merge the current slice into diff and derive flags from the merged value.
   always_comb begin
      diff_d = diff_q;
      for (int unsigned i = 0; i < N; i++) begin
         if (idx_q == IW'(i)) diff_d[i*SLICE +: SLICE] = sum;
      end
      flags_d.borrow = ~cout;
      flags_d.zero   = (diff_d == '0);
      flags_d.neg    = diff_d[WIDTH-1];
      flags_d.ovf    = (a_msb_q != b_msb_q) && (diff_d[WIDTH-1] != a_msb_q);
   end

   // Datapath: operand capture, slice stepping, result and flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         nb_q    <= '0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         diff_q  <= '0;
         flags_q <= '0;
         done_q  <= 1'b0;
      end else if (accept) begin
         a_q     <= a;
         nb_q    <= ~b;
         a_msb_q <= a[WIDTH-1];
         b_msb_q <= b[WIDTH-1];
         carry_q <= cin0;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else if (state_q == RUN) begin
         a_q     <= a_q >> SLICE;
         nb_q    <= nb_q >> SLICE;
         carry_q <= cout;
         diff_q  <= diff_d;
         if (last) begin
            flags_q <= flags_d;
            done_q  <= 1'b1;
            idx_q   <= '0;
         end else begin
            done_q  <= 1'b0;
            idx_q   <= idx_q + 1'b1;
         end
      end else begin
         done_q <= 1'b0;
      end
   end

   assign busy   = (state_q == RUN);
   assign done   = done_q;
   assign diff   = diff_q;
   assign borrow = flags_q.borrow;
   assign zero   = flags_q.zero;
   assign neg    = flags_q.neg;
   assign ovf    = flags_q.ovf;

endmodule

// File: tb/tb_byte_serial_sub.sv
// Directed bench for byte_serial_sub (WIDTH=32, SLICE=8).
module tb_byte_serial_sub;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] a, b;
   logic        bin_s;
   logic        busy, done, borrow, zero, neg, ovf;
   logic [31:0] diff;

   int errors = 0;
   int checks = 0;
   int done_pulses = 0;

   always #5 clk = ~clk;

   byte_serial_sub #(.WIDTH(32), .SLICE(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
`ifdef BYTE_SUB_BORROW_IN_EN
      .bin    (bin_s),
`endif
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow),
      .zero   (zero),
      .neg    (neg),
      .ovf    (ovf)
   );

   always @(negedge clk) if (done) done_pulses++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] flags();
      return {28'd0, borrow, zero, neg, ovf};
   endfunction

   task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic bi);
      @(negedge clk);
      a = av; b = bv; bin_s = bi; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   // flags expected as {borrow, zero, neg, ovf}
   task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic bi, input logic [31:0] ed, input logic [3:0] ef);
      int cyc;
      start_op(av, bv, bi);
      check({tag, ".busy"}, {31'd0, busy}, 32'd1);
      wait_done(cyc);
      check({tag, ".lat"}, cyc, 32'd4);
      check({tag, ".diff"}, diff, ed);
      check({tag, ".flags"}, flags(), {28'd0, ef});
      @(negedge clk);
      check({tag, ".done1cyc"}, {31'd0, done}, 32'd0);
      check({tag, ".hold"}, diff, ed);
   endtask

   initial begin
      int cyc;
      int pulses;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin_s = 1'b0;
      #2;
      check("rst.busy", {31'd0, busy}, 32'd0);
      check("rst.done", {31'd0, done}, 32'd0);
      check("rst.diff", diff, 32'd0);
      check("rst.flags", flags(), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("5m3",  32'd5,         32'd3,          1'b0, 32'h00000002, 4'b0000);
      run_op("3m5",  32'd3,         32'd5,          1'b0, 32'hFFFFFFFE, 4'b1010);
      run_op("0m1",  32'd0,         32'd1,          1'b0, 32'hFFFFFFFF, 4'b1010);
      run_op("minm1",32'h80000000,  32'd1,          1'b0, 32'h7FFFFFFF, 4'b0001);
      run_op("eq",   32'h1234ABCD,  32'h1234ABCD,   1'b0, 32'h00000000, 4'b0100);

      // back-to-back: second start issued in the done cycle
      start_op(32'h100, 32'h1, 1'b0);
      wait_done(cyc);
      check("b2b1.diff", diff, 32'h000000FF);
      check("b2b1.done", {31'd0, done}, 32'd1);
      a = 32'h7FFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b2.busy", {31'd0, busy}, 32'd1);
      wait_done(cyc);
      check("b2b2.lat", cyc, 32'd4);
      check("b2b2.diff", diff, 32'h80000000);
      check("b2b2.flags", flags(), 32'b1011);

      // start while busy is ignored; operand changes during RUN have no effect
      start_op(32'h00010000, 32'h1, 1'b0);
      a = 32'h0; b = 32'h5; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = 32'hDEADBEEF; b = 32'h12345678;
      wait_done(cyc);
      check("ign.lat", cyc, 32'd3);
      check("ign.diff", diff, 32'h0000FFFF);
      check("ign.flags", flags(), 32'b0000);
      repeat (3) @(negedge clk);
      check("ign.nodone", {31'd0, done}, 32'd0);
      check("ign.hold", diff, 32'h0000FFFF);

      // asynchronous reset mid-run
      start_op(32'hFF, 32'h1, 1'b0);
      @(negedge clk);
      pulses = done_pulses;
      rst_n = 1'b0;
      #1;
      check("mrst.busy", {31'd0, busy}, 32'd0);
      check("mrst.done", {31'd0, done}, 32'd0);
      check("mrst.diff", diff, 32'd0);
      check("mrst.flags", flags(), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("mrst.nopulse", done_pulses, pulses);
      check("mrst.idle", {31'd0, busy}, 32'd0);

`ifdef BYTE_SUB_BORROW_IN_EN
      run_op("bin", 32'h10, 32'h10, 1'b1, 32'hFFFFFFFF, 4'b1010);
      run_op("bin0", 32'h10, 32'h3, 1'b0, 32'h0000000D, 4'b0000);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/byte_serial_sub.md
Name: byte_serial_sub

Overview:
Multi-cycle WIDTH-bit subtractor that computes a − b one SLICE-bit slice per clock, least-significant slice first. It uses a single carry-lookahead slice and a registered carry chain (a + ~b + 1). It sits beside the single-cycle adder in the ALU and serves area-constrained SUB/CMP paths, with a start/done handshake and status flags.

Parameters:
WIDTH, 32, operand and result width; must be an integer multiple of SLICE.
SLICE, 8, bits processed per cycle.
N (localparam), WIDTH/SLICE, number of compute cycles.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only when busy=0.
a  input  WIDTH  minuend; captured on accepted start.
b  input  WIDTH  subtrahend; captured on accepted start.
busy  output  1  high while a subtraction is in progress.
done  output  1  single-cycle pulse: result and flags valid.
diff  output  WIDTH  a − b (mod 2^WIDTH).
borrow  output  1  1 when unsigned a < b (inverse of final carry).
zero  output  1  diff == 0.
neg  output  1  diff[WIDTH-1].
ovf  output  1  signed overflow.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0; done=0; diff=0; borrow=0; zero=0; neg=0; ovf=0; slice index=0; carry=0. Reset mid-operation aborts it with no done pulse.
- States: IDLE and RUN.
- IDLE:
  - start=1 at an edge → latch a, ~b, carry=1, idx=0 → RUN.
  - busy rises on the same edge.
  - diff and flags keep their previous values until the first slice is written.
- RUN, each edge:
  - slice idx of diff ← a_slice + ~b_slice + carry.
  - carry ← slice carry-out; idx++.
  - When idx==N-1 this edge writes the final slice and sets done=1, busy=0, borrow=~cout, zero, neg, ovf → IDLE.
- Latency: done is high during the Nth cycle after the start edge (4 cycles at default). Throughput is one op per N cycles.
- done is high for exactly one cycle. Its cycle is IDLE, so a start in that cycle is accepted (back-to-back ops).
- start while busy=1 is ignored; latched operands are unaffected by input changes during RUN.
- ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using latched operands.
- diff and flags hold after done until the next accepted start begins overwriting.
- Intermediate diff slices may be visible while busy; they are valid only when done=1.

Optional Feature:
BYTE_SUB_BORROW_IN_EN
- Defined: adds input port bin (1 bit), latched on accepted start; initial carry = ~bin, so diff = a − b − bin. Used for multi-word chaining with borrow.
- ovf: computed from latched a, b and the final diff with the same formula.
- Undefined: no bin port; initial carry fixed at 1.

Decomposition:
- Shared ALU package holds:
  - SLICE and WIDTH defaults.
  - State encoding typedef (IDLE, RUN).
  - Flag-struct typedef {borrow, zero, neg, ovf}.
- Sub-module cla_slice: SLICE-bit carry-lookahead adder (x, y, cin → s, cout) using generate/propagate equations, purely combinational, instantiated once.
- Top level owns the FSM, index counter, carry register and result/flag registers.

Test Plan:
- Reset then a=5, b=3, start one cycle → done after 4 cycles; diff=0x00000002, borrow=0, zero=0, neg=0, ovf=0.
- a=3, b=5 → diff=0xFFFFFFFE, borrow=1, neg=1, ovf=0.
- a=0x00000000, b=1, full borrow ripple across all slices → diff=0xFFFFFFFF, borrow=1.
- a=0x80000000, b=1 → diff=0x7FFFFFFF, ovf=1, borrow=0.
- a=b=0x1234ABCD → zero=1, borrow=0.
- Back-to-back start in the done cycle: 2nd op result correct.
- Pulse start while busy with different operands → ignored; first result unchanged.
- rst_n low in the middle of RUN → all outputs 0 immediately, no done pulse.
- With BYTE_SUB_BORROW_IN_EN: a=0x10, b=0x10, bin=1 → diff=0xFFFFFFFF, borrow=1.
